alarm_controller: RTL and testbench

- Alarm stage downstream of the time-keeping block and upstream of the seven-segment driver.
- Consumes the BCD time digits and the seconds count, and holds a user-set alarm time.
- Runs the arm/ring/snooze state machine, drives a blinking buzzer LED, and muxes the four digits sent to the display (alarm time while setting, live time otherwise).

---
 rtl/alarm_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_alarm_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm stage: holds the alarm time, runs the arm/ring/snooze FSM, blinks the buzzer
// and selects which four BCD digits go to the seven-segment driver.
module alarm_controller #(
    parameter int BLINK_DIV  = 25000000,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       CLK100MHZ,
    input  logic       Reset_n,
    input  logic [3:0] hours1,
    input  logic [3:0] hours2,
    input  logic [3:0] mins1,
    input  logic [3:0] mins2,
    input  logic [5:0] secs,
    input  logic       BtnSet,
    input  logic       BtnArm,
    input  logic       BtnSnooze,
    input  logic       BtnDismiss,
    input  logic       BtnH,
    input  logic       BtnM,
    output logic [3:0] DispH1,
    output logic [3:0] DispH2,
    output logic [3:0] DispM1,
    output logic [3:0] DispM2,
    output logic       Armed,
    output logic       Buzzer,
    output logic       Setting
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int RW = $clog2(RING_SECS + 1);

    typedef enum logic [2:0] {DISARMED, SET, ARMED, RINGING, SNOOZE} state_t;

    state_t state, state_next;

    logic [5:0]    btn, btn_q, press_q;
    logic          p_set, p_arm, p_snooze, p_dismiss, p_h, p_m;
    logic [3:0]    al_h1, al_h2, al_m1, al_m2;
    logic [3:0]    sz_h1, sz_h2, sz_m1, sz_m2;
    logic [3:0]    t_h1, t_h2, t_m1, t_m2;
    logic [3:0]    inc_h1, inc_h2, inc_m1, inc_m2;
    logic [3:0]    sn_h1, sn_h2, sn_m1, sn_m2;
    logic [4:0]    sn_sum, sn_adj;
    logic [3:0]    sn_m1c;
    logic          sn_c1, sn_c2;
    logic          match, match_q, match_qq, match_edge;
    logic [5:0]    secs_q;
    logic          secs_chg, timeout;
    logic          start_ring, take_snooze;
    logic [BW-1:0] blink_cnt;
    logic [RW-1:0] ring_cnt;
    logic          buzz;

    assign btn       = {BtnSet, BtnArm, BtnSnooze, BtnDismiss, BtnH, BtnM};
    assign p_set     = press_q[5];
    assign p_arm     = press_q[4];
    assign p_snooze  = press_q[3];
    assign p_dismiss = press_q[2];
    assign p_h       = press_q[1];
    assign p_m       = press_q[0];

    // Registered one-cycle press pulses, so a held button acts only once
    always_ff @(posedge CLK100MHZ or negedge Reset_n) begin
        if (!Reset_n) begin
            btn_q   <= '0;
            press_q <= '0;
        end else begin
            btn_q   <= btn;
            press_q <= btn & ~btn_q;
        end
    end

    always_comb begin
        t_h1 = al_h1;
        t_h2 = al_h2;
        t_m1 = al_m1;
        t_m2 = al_m2;
        if (state == SNOOZE) begin
            t_h1 = sz_h1;
            t_h2 = sz_h2;
            t_m1 = sz_m1;
            t_m2 = sz_m2;
        end
    end

    assign match      = ({hours1, hours2, mins1, mins2} == {t_h1, t_h2, t_m1, t_m2}) && (secs == 6'd0);
    assign match_edge = match_q & ~match_qq;
    assign secs_chg   = (secs != secs_q);
    assign timeout    = secs_chg && (ring_cnt == RW'(RING_SECS - 1));

    always_comb begin
        inc_h1 = al_h1;
        inc_h2 = al_h2 + 4'd1;
        if (al_h1 == 4'd2 && al_h2 == 4'd3) begin
            inc_h1 = 4'd0;
            inc_h2 = 4'd0;
        end else if (al_h2 == 4'd9) begin
            inc_h1 = al_h1 + 4'd1;
            inc_h2 = 4'd0;
        end
        inc_m1 = al_m1;
        inc_m2 = al_m2 + 4'd1;
        if (al_m2 == 4'd9) begin
            inc_m2 = 4'd0;
            inc_m1 = (al_m1 == 4'd5) ? 4'd0 : al_m1 + 4'd1;
        end
    end

    // Snooze target: live HH:MM + SNOOZE_MIN in BCD, wrapping past midnight
    always_comb begin
        sn_sum = {1'b0, mins2} + 5'(SNOOZE_MIN);
        sn_adj = sn_sum - 5'd10;
        sn_c1  = (sn_sum > 5'd9);
        sn_m2  = sn_c1 ? sn_adj[3:0] : sn_sum[3:0];
        sn_m1c = mins1 + {3'b000, sn_c1};
        sn_c2  = (sn_m1c == 4'd6);
        sn_m1  = sn_c2 ? 4'd0 : sn_m1c;
        sn_h1  = hours1;
        sn_h2  = hours2;
        if (sn_c2) begin
            if (hours1 == 4'd2 && hours2 == 4'd3) begin
                sn_h1 = 4'd0;
                sn_h2 = 4'd0;
            end else if (hours2 == 4'd9) begin
                sn_h1 = hours1 + 4'd1;
                sn_h2 = 4'd0;
            end else begin
                sn_h2 = hours2 + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge Reset_n) begin
        if (!Reset_n) state <= DISARMED;
        else          state <= state_next;
    end

    // Event priority within a state: Arm > Dismiss > Snooze > match > timeout
    always_comb begin
        state_next  = state;
        start_ring  = 1'b0;
        take_snooze = 1'b0;
        case (state)
            DISARMED: begin
                if (p_arm)      state_next = ARMED;
                else if (p_set) state_next = SET;
            end
            SET: begin
                if (p_set) state_next = DISARMED;
            end
            ARMED: begin
                if (p_arm)      state_next = DISARMED;
                else if (p_set) state_next = SET;
                else if (match_edge) begin
                    state_next = RINGING;
                    start_ring = 1'b1;
                end
            end
            RINGING: begin
                if (p_arm)          state_next = DISARMED;
                else if (p_dismiss) state_next = ARMED;
                else if (p_snooze) begin
                    state_next  = SNOOZE;
                    take_snooze = 1'b1;
                end else if (timeout) state_next = ARMED;
            end
            SNOOZE: begin
                if (p_arm)          state_next = DISARMED;
                else if (p_dismiss) state_next = ARMED;
                else if (match_edge) begin
                    state_next = RINGING;
                    start_ring = 1'b1;
                end
            end
            default: state_next = DISARMED;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge Reset_n) begin
        if (!Reset_n) begin
            al_h1     <= '0;
            al_h2     <= '0;
            al_m1     <= '0;
            al_m2     <= '0;
            sz_h1     <= '0;
            sz_h2     <= '0;
            sz_m1     <= '0;
            sz_m2     <= '0;
            match_q   <= 1'b0;
            match_qq  <= 1'b0;
            secs_q    <= '0;
            blink_cnt <= '0;
            ring_cnt  <= '0;
            buzz      <= 1'b0;
            DispH1    <= '0;
            DispH2    <= '0;
            DispM1    <= '0;
            DispM2    <= '0;
        end else begin
            match_q  <= match;
            match_qq <= match_q;
            secs_q   <= secs;
            if (state == SET) begin
                if (p_h) begin
                    al_h1 <= inc_h1;
                    al_h2 <= inc_h2;
                end
                if (p_m) begin
                    al_m1 <= inc_m1;
                    al_m2 <= inc_m2;
                end
            end
            if (take_snooze) begin
                sz_h1 <= sn_h1;
                sz_h2 <= sn_h2;
                sz_m1 <= sn_m1;
                sz_m2 <= sn_m2;
            end
            if (start_ring) begin
                blink_cnt <= '0;
                ring_cnt  <= '0;
                buzz      <= 1'b1;
            end else if (state == RINGING) begin
                if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                    blink_cnt <= '0;
                    buzz      <= ~buzz;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
                if (secs_chg) ring_cnt <= ring_cnt + 1'b1;
            end
            if (state == SET) begin
                {DispH1, DispH2, DispM1, DispM2} <= {al_h1, al_h2, al_m1, al_m2};
            end else begin
                {DispH1, DispH2, DispM1, DispM2} <= {hours1, hours2, mins1, mins2};
            end
        end
    end

    // Gating with the state register drops the buzzer the moment RINGING is left
    assign Buzzer  = buzz && (state == RINGING);
    assign Armed   = (state == ARMED) || (state == RINGING) || (state == SNOOZE);
    assign Setting = (state == SET);

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with a short blink period, 3 s ring and 5 min snooze.
module tb_alarm_controller;

    localparam logic [5:0] B_SET = 6'b100000;
    localparam logic [5:0] B_ARM = 6'b010000;
    localparam logic [5:0] B_SNZ = 6'b001000;
    localparam logic [5:0] B_DIS = 6'b000100;
    localparam logic [5:0] B_H   = 6'b000010;
    localparam logic [5:0] B_M   = 6'b000001;

    logic       CLK100MHZ = 1'b0;
    logic       Reset_n;
    logic [3:0] hours1, hours2, mins1, mins2;
    logic [5:0] secs;
    logic       BtnSet, BtnArm, BtnSnooze, BtnDismiss, BtnH, BtnM;
    logic [3:0] DispH1, DispH2, DispM1, DispM2;
    logic       Armed, Buzzer, Setting;

    int checks = 0;
    int errors = 0;

    alarm_controller #(
        .BLINK_DIV (4),
        .RING_SECS (3),
        .SNOOZE_MIN(5)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .Reset_n   (Reset_n),
        .hours1    (hours1),
        .hours2    (hours2),
        .mins1     (mins1),
        .mins2     (mins2),
        .secs      (secs),
        .BtnSet    (BtnSet),
        .BtnArm    (BtnArm),
        .BtnSnooze (BtnSnooze),
        .BtnDismiss(BtnDismiss),
        .BtnH      (BtnH),
        .BtnM      (BtnM),
        .DispH1    (DispH1),
        .DispH2    (DispH2),
        .DispM1    (DispM1),
        .DispM2    (DispM2),
        .Armed     (Armed),
        .Buzzer    (Buzzer),
        .Setting   (Setting)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic press(input logic [5:0] mask);
        {BtnSet, BtnArm, BtnSnooze, BtnDismiss, BtnH, BtnM} = mask;
        tick(2);
        {BtnSet, BtnArm, BtnSnooze, BtnDismiss, BtnH, BtnM} = 6'b0;
        tick(1);
    endtask

    task automatic set_live(input logic [3:0] h1, input logic [3:0] h2,
                            input logic [3:0] m1, input logic [3:0] m2, input logic [5:0] s);
        hours1 = h1;
        hours2 = h2;
        mins1  = m1;
        mins2  = m2;
        secs   = s;
    endtask

    task automatic ring_at_0730();
        set_live(4'd0, 4'd7, 4'd2, 4'd9, 6'd59);
        tick(3);
        set_live(4'd0, 4'd7, 4'd3, 4'd0, 6'd0);
        tick(2);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        {BtnSet, BtnArm, BtnSnooze, BtnDismiss, BtnH, BtnM} = 6'b0;
        set_live(4'd1, 4'd2, 4'd3, 4'd4, 6'd56);
        #3;
        checks++; if (Armed !== 1'b0)   begin errors++; $display("[TB] FAIL reset_armed got %b expected 0", Armed); end
        checks++; if (Buzzer !== 1'b0)  begin errors++; $display("[TB] FAIL reset_buzzer got %b expected 0", Buzzer); end
        checks++; if (Setting !== 1'b0) begin errors++; $display("[TB] FAIL reset_setting got %b expected 0", Setting); end
        tick(2);
        Reset_n = 1'b1;
        tick(2);
        checks++; if ({DispH1, DispH2, DispM1, DispM2} !== 16'h1234)
            begin errors++; $display("[TB] FAIL reset_disp_live got %h expected 1234", {DispH1, DispH2, DispM1, DispM2}); end
    endtask

    task automatic test_set();
        press(B_SET);
        checks++; if (Setting !== 1'b1) begin errors++; $display("[TB] FAIL set_enter got %b expected 1", Setting); end
        checks++; if ({DispH1, DispH2, DispM1, DispM2} !== 16'h0000)
            begin errors++; $display("[TB] FAIL set_disp_init got %h expected 0000", {DispH1, DispH2, DispM1, DispM2}); end
        for (int i = 0; i < 23; i++) press(B_H);
        checks++; if ({DispH1, DispH2, DispM1, DispM2} !== 16'h2300)
            begin errors++; $display("[TB] FAIL set_hour23 got %h expected 2300", {DispH1, DispH2, DispM1, DispM2}); end
        press(B_H);
        checks++; if ({DispH1, DispH2, DispM1, DispM2} !== 16'h0000)
            begin errors++; $display("[TB] FAIL set_hour_wrap got %h expected 0000", {DispH1, DispH2, DispM1, DispM2}); end
        for (int i = 0; i < 59; i++) press(B_M);
        checks++; if ({DispH1, DispH2, DispM1, DispM2} !== 16'h0059)
            begin errors++; $display("[TB] FAIL set_min59 got %h expected 0059", {DispH1, DispH2, DispM1, DispM2}); end
        press(B_M);
        checks++; if ({DispH1, DispH2, DispM1, DispM2} !== 16'h0000)
            begin errors++; $display("[TB] FAIL set_min_wrap got %h expected 0000", {DispH1, DispH2, DispM1, DispM2}); end
        for (int i = 0; i < 7; i++) press(B_H);
        for (int i = 0; i < 30; i++) press(B_M);
        checks++; if ({DispH1, DispH2, DispM1, DispM2} !== 16'h0730)
            begin errors++; $display("[TB] FAIL set_0730 got %h expected 0730", {DispH1, DispH2, DispM1, DispM2}); end
        press(B_H | B_M);
        checks++; if ({DispH1, DispH2, DispM1, DispM2} !== 16'h0831)
            begin errors++; $display("[TB] FAIL set_h_and_m got %h expected 0831", {DispH1, DispH2, DispM1, DispM2}); end
        for (int i = 0; i < 23; i++) press(B_H);
        for (int i = 0; i < 59; i++) press(B_M);
        checks++; if ({DispH1, DispH2, DispM1, DispM2} !== 16'h0730)
            begin errors++; $display("[TB] FAIL set_restore got %h expected 0730", {DispH1, DispH2, DispM1, DispM2}); end
        press(B_ARM);
        press(B_SNZ | B_DIS);
        checks++; if (Setting !== 1'b1 || Armed !== 1'b0)
            begin errors++; $display("[TB] FAIL set_ignore got setting=%b armed=%b expected setting=1 armed=0", Setting, Armed); end
        press(B_SET);
        checks++; if (Setting !== 1'b0 || Armed !== 1'b0)
            begin errors++; $display("[TB] FAIL set_exit got setting=%b armed=%b expected setting=0 armed=0", Setting, Armed); end
        checks++; if ({DispH1, DispH2, DispM1, DispM2} !== 16'h1234)
            begin errors++; $display("[TB] FAIL set_exit_disp got %h expected 1234", {DispH1, DispH2, DispM1, DispM2}); end
    endtask

    task automatic test_ring();
        press(B_ARM);
        checks++; if (Armed !== 1'b1) begin errors++; $display("[TB] FAIL ring_armed got %b expected 1", Armed); end
        set_live(4'd0, 4'd7, 4'd2, 4'd9, 6'd59);
        tick(3);
        set_live(4'd0, 4'd7, 4'd3, 4'd0, 6'd0);
        tick(1);
        checks++; if (Buzzer !== 1'b0) begin errors++; $display("[TB] FAIL ring_early got %b expected 0", Buzzer); end
        tick(1);
        checks++; if (Buzzer !== 1'b1) begin errors++; $display("[TB] FAIL ring_start got %b expected 1", Buzzer); end
        tick(3);
        checks++; if (Buzzer !== 1'b1) begin errors++; $display("[TB] FAIL blink_hold got %b expected 1", Buzzer); end
        tick(1);
        checks++; if (Buzzer !== 1'b0) begin errors++; $display("[TB] FAIL blink_low got %b expected 0", Buzzer); end
        tick(4);
        checks++; if (Buzzer !== 1'b1) begin errors++; $display("[TB] FAIL blink_high got %b expected 1", Buzzer); end
        press(B_DIS);
        checks++; if (Buzzer !== 1'b0 || Armed !== 1'b1)
            begin errors++; $display("[TB] FAIL dismiss got buzzer=%b armed=%b expected buzzer=0 armed=1", Buzzer, Armed); end
        tick(10);
        checks++; if (Buzzer !== 1'b0) begin errors++; $display("[TB] FAIL no_retrigger got %b expected 0", Buzzer); end
    endtask

    task automatic test_timeout();
        ring_at_0730();
        checks++; if (Buzzer !== 1'b1) begin errors++; $display("[TB] FAIL timeout_start got %b expected 1", Buzzer); end
        secs = 6'd1;
        tick(1);
        secs = 6'd2;
        tick(1);
        checks++; if (Buzzer !== 1'b1) begin errors++; $display("[TB] FAIL timeout_early got %b expected 1", Buzzer); end
        secs = 6'd3;
        tick(1);
        checks++; if (Buzzer !== 1'b0 || Armed !== 1'b1)
            begin errors++; $display("[TB] FAIL timeout_end got buzzer=%b armed=%b expected buzzer=0 armed=1", Buzzer, Armed); end
        tick(5);
        checks++; if (Buzzer !== 1'b0) begin errors++; $display("[TB] FAIL timeout_stay got %b expected 0", Buzzer); end
    endtask

    task automatic test_snooze();
        ring_at_0730();
        checks++; if (Buzzer !== 1'b1) begin errors++; $display("[TB] FAIL snooze_ring got %b expected 1", Buzzer); end
        set_live(4'd0, 4'd7, 4'd5, 4'd8, 6'd0);
        press(B_SNZ);
        checks++; if (Buzzer !== 1'b0 || Armed !== 1'b1)
            begin errors++; $display("[TB] FAIL snooze_enter got buzzer=%b armed=%b expected buzzer=0 armed=1", Buzzer, Armed); end
        set_live(4'd0, 4'd8, 4'd0, 4'd2, 6'd59);
        tick(3);
        checks++; if (Buzzer !== 1'b0) begin errors++; $display("[TB] FAIL snooze_wait got %b expected 0", Buzzer); end
        set_live(4'd0, 4'd8, 4'd0, 4'd3, 6'd0);
        tick(2);
        checks++; if (Buzzer !== 1'b1) begin errors++; $display("[TB] FAIL snooze_reRing got %b expected 1", Buzzer); end
        checks++; if ({DispH1, DispH2, DispM1, DispM2} !== 16'h0803)
            begin errors++; $display("[TB] FAIL snooze_disp got %h expected 0803", {DispH1, DispH2, DispM1, DispM2}); end
    endtask

    task automatic test_snooze_wrap();
        set_live(4'd2, 4'd3, 4'd5, 4'd7, 6'd0);
        press(B_SNZ);
        checks++; if (Buzzer !== 1'b0) begin errors++; $display("[TB] FAIL wrap_enter got %b expected 0", Buzzer); end
        set_live(4'd0, 4'd0, 4'd0, 4'd1, 6'd59);
        tick(3);
        checks++; if (Buzzer !== 1'b0) begin errors++; $display("[TB] FAIL wrap_wait got %b expected 0", Buzzer); end
        set_live(4'd0, 4'd0, 4'd0, 4'd2, 6'd0);
        tick(2);
        checks++; if (Buzzer !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ring got %b expected 1", Buzzer); end
        checks++; if ({DispH1, DispH2, DispM1, DispM2} !== 16'h0002)
            begin errors++; $display("[TB] FAIL wrap_disp got %h expected 0002", {DispH1, DispH2, DispM1, DispM2}); end
    endtask

    task automatic test_back_to_back();
        press(B_ARM | B_DIS);
        checks++; if (Armed !== 1'b0 || Buzzer !== 1'b0)
            begin errors++; $display("[TB] FAIL arm_over_dismiss got armed=%b buzzer=%b expected armed=0 buzzer=0", Armed, Buzzer); end
    endtask

    task automatic test_reset_midring();
        press(B_ARM);
        ring_at_0730();
        checks++; if (Buzzer !== 1'b1) begin errors++; $display("[TB] FAIL midring_start got %b expected 1", Buzzer); end
        Reset_n = 1'b0;
        #1;
        checks++; if (Buzzer !== 1'b0 || Armed !== 1'b0)
            begin errors++; $display("[TB] FAIL midring_async got buzzer=%b armed=%b expected buzzer=0 armed=0", Buzzer, Armed); end
        tick(2);
        Reset_n = 1'b1;
        tick(1);
        press(B_SET);
        checks++; if (Setting !== 1'b1 || {DispH1, DispH2, DispM1, DispM2} !== 16'h0000)
            begin errors++; $display("[TB] FAIL midring_alarm got setting=%b disp=%h expected setting=1 disp=0000", Setting, {DispH1, DispH2, DispM1, DispM2}); end
    endtask

    initial begin
        test_reset();
        test_set();
        test_ring();
        test_timeout();
        test_snooze();
        test_snooze_wrap();
        test_back_to_back();
        test_reset_midring();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
